lamp_serializer: RTL
====================

LAMP_SERIALIZER -- requirements
Module: lamp_serializer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per sclk half-period (legal range 1..255).
REQ-002 SHALL have parameter LAMP_W, default 16, meaning lamp vector width.
REQ-003 SHALL have port clk  input  1  the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port lamps  input  LAMP_W  parallel lamp pattern from the flasher stage.
REQ-006 SHALL have port sclk  output  1  serial shift clock to the external shift-register chain.
REQ-007 SHALL have port sdata  output  1  serial data, MSB first.
REQ-008 SHALL have port latch  output  1  storage-register strobe, active-high.
REQ-009 SHALL have port busy  output  1  high while a frame is in progress.

Function
REQ-010 SHALL implement the states IDLE, SHIFT, LATCH; busy SHALL be 1 exactly when state != IDLE.
REQ-011 IDLE: when lamps != last_sent or force_frame==1, the block SHALL capture lamps into shadow, set bit_cnt=LAMP_W-1, clear force_frame, and enter SHIFT on that edge.
REQ-012 SHIFT SHALL drive sdata = shadow[bit_cnt] and hold sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles, per bit.
REQ-013 At the end of each high phase, the block SHALL decrement bit_cnt when bit_cnt>0; when bit_cnt==0 it SHALL enter LATCH with sclk=0.
REQ-014 sdata SHALL change only on the cycle sclk goes 0, never while sclk=1.
REQ-015 LATCH SHALL hold latch=1 for CLK_DIV cycles, then set last_sent=shadow and return to IDLE with latch=0.
REQ-016 A frame SHALL last exactly (2*LAMP_W+1)*CLK_DIV cycles of busy=1; with the defaults, this is 132 cycles.
REQ-017 Changes on lamps while busy=1 SHALL NOT affect the frame in flight.
REQ-018 If lamps differs from last_sent at the first IDLE cycle after a frame, the next frame SHALL start on that cycle, giving exactly one idle cycle between frames.
REQ-019 sclk, sdata, latch and busy SHALL be driven directly from flops, with no combinational path from lamps.
REQ-020 The half-period counter SHALL reload to CLK_DIV-1 on every phase change and on entry to SHIFT or LATCH.

Reset
REQ-021 Reset SHALL force state=IDLE, sclk=0, sdata=0, latch=0, busy=0, bit_cnt=0, counter=0, shadow=0, last_sent=0, force_frame=1.
REQ-022 Asserting rst mid-frame SHALL abort the frame immediately, with no latch pulse.
REQ-023 After rst is released, the block SHALL send one frame of the current lamps value, even when that value is 0.

Structure
REQ-024 A shared package lamp_pkg SHALL hold the state enum (IDLE, SHIFT, LATCH) and the constant LAMP_W_DEFAULT=16.
REQ-025 A sub-module half_period_timer SHALL hold the down-counter and generate a one-cycle tick every CLK_DIV cycles while enabled.
REQ-026 The parent SHALL contain only the FSM, the shadow and last_sent registers, and the output flops.

Verification
REQ-027 Scenario 1: release rst with lamps=16'h0000 -> one frame of 16 zero bits, 16 sclk rising edges, a 4-cycle latch pulse, and busy high for 132 cycles.
REQ-028 Scenario 2: lamps changes from 16'h0000 to 16'h003F in IDLE -> sdata on the 16 sclk rising edges reads 0000000000111111, then a latch pulse.
REQ-029 Scenario 3: lamps changes 16'h003F -> 16'h007F -> 16'h00FF during one frame -> the current frame completes unchanged, one idle cycle follows, and the next frame sends 16'h00FF only.
REQ-030 Scenario 4: assert rst after the 7th sclk rising edge of a frame with lamps=16'hFFFF -> outputs are 0 asynchronously, no latch pulse occurs, and the full frame is resent after release.
REQ-031 Scenario 5: hold lamps at 16'h07FF after its frame completes -> busy stays 0 and sclk/latch stay idle for 1000 cycles.
REQ-032 Scenario 6: CLK_DIV=1, lamps=16'hA5A5 -> a 33-cycle frame, sclk toggling every cycle, and a serial stream of 1010010110100101.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared types and defaults for the lamp serializer block.
package lamp_pkg;
  localparam int LAMP_W_DEFAULT = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
endpackage

// File: rtl/lamp_serializer_if.sv
// Parallel-lamp in / serial shift-chain out bundle for the lamp serializer.
interface lamp_serializer_if import lamp_pkg::*; #(
  parameter int LAMP_W = LAMP_W_DEFAULT
);
  logic [LAMP_W-1:0] lamps;
  logic              sclk;
  logic              sdata;
  logic              latch;
  logic              busy;

  modport master (output lamps, input sclk, sdata, latch, busy);
  modport slave  (input lamps, output sclk, sdata, latch, busy);
endinterface

// File: rtl/half_period_timer.sv
// Down-counter producing a one-cycle tick every CLK_DIV enabled cycles.
module half_period_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic load,
  output logic tick
);
  localparam logic [7:0] RELOAD = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  // The tick itself reloads, so every phase boundary restarts the count.
  assign tick = en && (cnt == 8'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= 8'd0;
    else if (load || tick) cnt <= RELOAD;
    else if (en)          cnt <= cnt - 8'd1;
  end
endmodule

// File: rtl/lamp_serializer.sv
// Shifts a lamp pattern MSB-first into an external shift-register chain, then latches it.
module lamp_serializer import lamp_pkg::*; #(
  parameter int CLK_DIV = 4,
  parameter int LAMP_W  = LAMP_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LAMP_W-1:0] lamps,
  output logic              sclk,
  output logic              sdata,
  output logic              latch,
  output logic              busy
);
  localparam int CW = (LAMP_W > 1) ? $clog2(LAMP_W) : 1;

  state_t            state;
  logic [LAMP_W-1:0] shadow;
  logic [LAMP_W-1:0] last_sent;
  logic [CW-1:0]     bit_cnt;
  logic [CW-1:0]     next_bit;
  logic              force_frame;
  logic              start;
  logic              tick;

  assign start    = (state == IDLE) && ((lamps != last_sent) || force_frame);
  assign next_bit = bit_cnt - 1'b1;

  half_period_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .load (start),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sclk        <= 1'b0;
      sdata       <= 1'b0;
      latch       <= 1'b0;
      busy        <= 1'b0;
      bit_cnt     <= '0;
      shadow      <= '0;
      last_sent   <= '0;
      force_frame <= 1'b1;
    end else begin
      case (state)
        IDLE: if (start) begin
          shadow      <= lamps;
          bit_cnt     <= CW'(LAMP_W - 1);
          force_frame <= 1'b0;
          sdata       <= lamps[LAMP_W-1];
          sclk        <= 1'b0;
          busy        <= 1'b1;
          state       <= SHIFT;
        end
        SHIFT: if (tick) begin
          if (!sclk) begin
            sclk <= 1'b1;
          end else if (bit_cnt != '0) begin
            // sdata moves only together with the falling sclk edge
            bit_cnt <= next_bit;
            sclk    <= 1'b0;
            sdata   <= shadow[next_bit];
          end else begin
            sclk  <= 1'b0;
            latch <= 1'b1;
            state <= LATCH;
          end
        end
        LATCH: if (tick) begin
          latch     <= 1'b0;
          busy      <= 1'b0;
          last_sent <= shadow;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
